rca_32: RTL and testbench

RCA_32 -- requirements
Module: rca_32

---
 rtl/rca_pkg.sv | 6 +
 rtl/full_adder.sv | 14 +
 rtl/rca_32.sv | 83 ++++++++
 tb/tb_rca_32.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/rca_pkg.sv
// Shared constants for the 32-bit ripple-carry adder/subtractor.
package rca_pkg;
    localparam int RCA_WIDTH = 32;
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/full_adder.sv
// One-bit full adder: the single stage that rca_32 chains into a ripple adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    logic p;

    assign p    = a ^ b;
    assign s    = p ^ cin;
    assign cout = (a & b) | (cin & p);
endmodule

// File: rtl/rca_32.sv
// Registered 32-bit ripple-carry add/subtract unit; the overflow port and its logic
// exist only when RCA_32_OVF_EN is defined.
module rca_32
    import rca_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [RCA_WIDTH-1:0] src1,
    input  logic [RCA_WIDTH-1:0] src2,
    input  logic                 sub_flag,
    output logic [RCA_WIDTH-1:0] sum,
    output logic                 carry_out
`ifdef RCA_32_OVF_EN
    ,
    output logic                 overflow
`endif
);
    // No handshake: every rising edge captures src1/src2/sub_flag and the result
    // is visible on the outputs one cycle later, a new operation each cycle.

    logic                 is_sub;
    logic [RCA_WIDTH-1:0] b_in;
    logic [RCA_WIDTH:0]   carry;
    logic [RCA_WIDTH-1:0] chain_sum;

    logic [RCA_WIDTH-1:0] sum_d, sum_q;
    logic                 carry_d, carry_q;

    assign is_sub   = (sub_flag == OP_SUB);
    assign carry[0] = is_sub;

    // Subtraction as A + ~B + 1: invert B here, inject the +1 as carry-in.
    always_comb begin
        b_in = src2 ^ {RCA_WIDTH{is_sub}};
    end

    for (genvar i = 0; i < RCA_WIDTH; i++) begin : g_stage
        full_adder u_fa (
            .a    (src1[i]),
            .b    (b_in[i]),
            .cin  (carry[i]),
            .s    (chain_sum[i]),
            .cout (carry[i+1])
        );
    end

    always_comb begin
        sum_d   = chain_sum;
        carry_d = carry[RCA_WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    assign sum       = sum_q;
    assign carry_out = carry_q;

`ifdef RCA_32_OVF_EN
    logic ovf_d, ovf_q;

    // Signed overflow: carry into the sign bit disagrees with carry out of it.
    always_comb begin
        ovf_d = carry[RCA_WIDTH-1] ^ carry[RCA_WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign overflow = ovf_q;
`endif
endmodule

// File: tb/tb_rca_32.sv
// Self-checking bench for rca_32: directed corner cases, reset behaviour and
// randomized back-to-back add/subtract against an arithmetic reference model.
module tb_rca_32;
    import rca_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] src1 = '0;
    logic [31:0] src2 = '0;
    logic        sub_flag = 1'b0;
    logic [31:0] sum;
    logic        carry_out;
`ifdef RCA_32_OVF_EN
    logic        overflow;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rca_32 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .src1      (src1),
        .src2      (src2),
        .sub_flag  (sub_flag),
        .sum       (sum),
        .carry_out (carry_out)
`ifdef RCA_32_OVF_EN
        ,
        .overflow  (overflow)
`endif
    );

    // Reference: plain integer arithmetic on the operands.
    // Returns {overflow, carry, sum}.
    function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic op);
        logic [32:0] r;
        logic        ovf;
        if (op == OP_SUB) begin
            r[31:0] = a - b;
            r[32]   = (a >= b);
            ovf     = (a[31] != b[31]) && (r[31] != a[31]);
        end else begin
            r   = {1'b0, a} + {1'b0, b};
            ovf = (a[31] == b[31]) && (r[31] != a[31]);
        end
        return {ovf, r};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_zero(input string tag);
        check({tag, "_sum"}, sum, 32'h0);
        check({tag, "_carry"}, {31'b0, carry_out}, 32'h0);
`ifdef RCA_32_OVF_EN
        check({tag, "_ovf"}, {31'b0, overflow}, 32'h0);
`endif
    endtask

    // Apply one operation, let the next edge capture it, then check the result.
    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic op);
        logic [33:0] exp;
        src1     = a;
        src2     = b;
        sub_flag = op;
        exp      = model(a, b, op);
        @(posedge clk);
        #1;
        check({tag, "_sum"}, sum, exp[31:0]);
        check({tag, "_carry"}, {31'b0, carry_out}, {31'b0, exp[32]});
`ifdef RCA_32_OVF_EN
        check({tag, "_ovf"}, {31'b0, overflow}, {31'b0, exp[33]});
`endif
    endtask

    initial begin
        logic [31:0] ra, rb, held_sum;
        logic        held_carry;

        // Reset active with inputs toggling: outputs stay zero, no edge needed.
        #1;
        check_reset_zero("rst_initial");
        for (int i = 0; i < 4; i++) begin
            src1     = $urandom;
            src2     = $urandom;
            sub_flag = 1'($urandom_range(0, 1));
            #3;
            check_reset_zero("rst_toggle");
        end

        // Release away from the active edge; first capture is the next rising edge.
        @(negedge clk);
        rst_n = 1'b1;

        do_op("add_5_3", 32'h5, 32'h3, OP_ADD);
        check("add_5_3_exact", sum, 32'h8);
        do_op("add_wrap", 32'hFFFF_FFFF, 32'h1, OP_ADD);
        check("add_wrap_exact", {carry_out, sum[30:0]}, 32'h8000_0000);
        do_op("sub_borrow", 32'h0, 32'h1, OP_SUB);
        check("sub_borrow_exact", sum, 32'hFFFF_FFFF);
        do_op("sub_equal", 32'h7, 32'h7, OP_SUB);
        check("sub_equal_carry", {31'b0, carry_out}, 32'h1);
        do_op("ovf_add", 32'h7FFF_FFFF, 32'h1, OP_ADD);
        check("ovf_add_exact", sum, 32'h8000_0000);
        do_op("ovf_sub", 32'h8000_0000, 32'h1, OP_SUB);
        check("ovf_sub_exact", sum, 32'h7FFF_FFFF);
        do_op("sub_min", 32'h0000_0010, 32'h8000_0000, OP_SUB);
        do_op("add_neg", 32'h8000_0000, 32'h8000_0000, OP_ADD);

        // Outputs hold between edges even when inputs change.
        held_sum   = sum;
        held_carry = carry_out;
        src1 = $urandom;
        src2 = $urandom;
        sub_flag = ~sub_flag;
        #3;
        check("hold_sum", sum, held_sum);
        check("hold_carry", {31'b0, carry_out}, {31'b0, held_carry});

        // Mid-operation reset clears outputs at once and discards the in-flight result.
        do_op("pre_rst", 32'h5, 32'h3, OP_ADD);
        src1 = 32'hFFFF_FFFF;
        src2 = 32'h1;
        sub_flag = OP_ADD;
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_zero("rst_async");
        @(posedge clk);
        #1;
        check_reset_zero("rst_held");
        @(negedge clk);
        rst_n = 1'b1;
        do_op("post_rst", 32'h1234_5678, 32'h1111_1111, OP_SUB);

        // Randomized back-to-back traffic, sub_flag alternating every cycle.
        for (int i = 0; i < 240; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 9))
                0: rb = ra;
                1: ra = 32'hFFFF_FFFF;
                2: rb = 32'h8000_0000;
                3: ra = 32'h7FFF_FFFF;
                default: ;
            endcase
            do_op((i % 2 == 0) ? "rand_add" : "rand_sub", ra, rb, (i % 2 == 0) ? OP_ADD : OP_SUB);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
